// File: rtl/modn_seq_checker.sv
// Receive-side monitor for a mod-N up/down counter bus: locks onto a legal
// wrap-around sequence, flags sequence/range violations and counts wraps and errors.
module modn_seq_checker #(
    parameter int N        = 5,
    parameter int W        = 4,
    parameter int LOCK_CNT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         sample_en,
    input  logic         up_down,
    input  logic [W-1:0] count_in,
    output logic         locked,
    output logic         seq_err,
    output logic         range_err,
    output logic [7:0]   err_cnt,
    output logic [7:0]   wrap_cnt,
    output logic [W-1:0] expected
);

    localparam int RW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [W-1:0]  MAXV     = W'(N - 1);
    localparam logic [RW-1:0] LOCK_RUN = RW'(LOCK_CNT);

    typedef enum logic [1:0] {HUNT, LOCK, TRACK} state_t;

    state_t         state, state_n;
    logic [W-1:0]   last, last_n;
    logic [RW-1:0]  run, run_n;
    logic           seq_err_n, range_err_n;
    logic [7:0]     err_cnt_n, wrap_cnt_n;
    logic           match, wrap_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            last      <= '0;
            run       <= '0;
            seq_err   <= 1'b0;
            range_err <= 1'b0;
            err_cnt   <= 8'd0;
            wrap_cnt  <= 8'd0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            run       <= run_n;
            seq_err   <= seq_err_n;
            range_err <= range_err_n;
            err_cnt   <= err_cnt_n;
            wrap_cnt  <= wrap_cnt_n;
        end
    end

    // A step is a wrap when it crosses the N-1 / 0 boundary in its own direction.
    assign match     = (count_in == expected);
    assign wrap_step = up_down ? (last == MAXV) : (last == '0);

    always_comb begin
        state_n     = state;
        last_n      = last;
        run_n       = run;
        seq_err_n   = 1'b0;
        range_err_n = 1'b0;
        err_cnt_n   = err_cnt;
        wrap_cnt_n  = wrap_cnt;

        if (clear) begin
            state_n    = HUNT;
            run_n      = '0;
            err_cnt_n  = 8'd0;
            wrap_cnt_n = 8'd0;
        end else if (sample_en) begin
            if (count_in > MAXV) begin
                range_err_n = 1'b1;
                state_n     = HUNT;
                if (err_cnt != 8'hFF) err_cnt_n = err_cnt + 8'd1;
            end else begin
                case (state)
                    HUNT: begin
                        last_n  = count_in;
                        run_n   = '0;
                        state_n = LOCK;
                    end
                    LOCK: begin
                        last_n = count_in;
                        if (match) begin
                            run_n = run + RW'(1);
                            if (run + RW'(1) == LOCK_RUN) state_n = TRACK;
                        end else begin
                            run_n = '0;
                        end
                    end
                    TRACK: begin
                        last_n = count_in;
                        if (match) begin
                            if (wrap_step && wrap_cnt != 8'hFF) wrap_cnt_n = wrap_cnt + 8'd1;
                        end else begin
                            seq_err_n = 1'b1;
                            run_n     = '0;
                            state_n   = LOCK;
                            if (err_cnt != 8'hFF) err_cnt_n = err_cnt + 8'd1;
                        end
                    end
                    default: state_n = HUNT;
                endcase
            end
        end
    end

    always_comb begin
        locked = (state == TRACK);
        if (up_down)
            expected = (last == MAXV) ? '0 : last + W'(1);
        else
            expected = (last == '0) ? MAXV : last - W'(1);
    end

endmodule

// File: tb/tb_modn_seq_checker.sv
// Directed self-checking bench for modn_seq_checker (N=5, LOCK_CNT=2).
module tb_modn_seq_checker;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       sample_en;
    logic       up_down;
    logic [3:0] count_in;
    logic       locked;
    logic       seq_err;
    logic       range_err;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic [3:0] expected;

    int vectors;
    int miscompares;

    modn_seq_checker #(.N(5), .W(4), .LOCK_CNT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .sample_en (sample_en),
        .up_down   (up_down),
        .count_in  (count_in),
        .locked    (locked),
        .seq_err   (seq_err),
        .range_err (range_err),
        .err_cnt   (err_cnt),
        .wrap_cnt  (wrap_cnt),
        .expected  (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, required);
        end
    endtask

    // Drives one cycle of inputs and returns just after the sampling edge.
    task automatic applyStimulus(input logic clr, input logic en, input logic ud, input logic [3:0] val);
        clear     = clr;
        sample_en = en;
        up_down   = ud;
        count_in  = val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        clear       = 1'b0;
        sample_en   = 1'b0;
        up_down     = 1'b1;
        count_in    = 4'd0;
        #12;
        checkOutput("rst_locked", 32'(locked), 0);
        checkOutput("rst_errcnt", 32'(err_cnt), 0);
        checkOutput("rst_wrapcnt", 32'(wrap_cnt), 0);
        checkOutput("rst_expected", 32'(expected), 1);
        @(negedge clk);
        rst = 1'b1;

        // Lock and wrap going up: 3,4,0 locks; 1,2,3,4,0 gives one counted wrap.
        applyStimulus(0, 1, 1, 4'd3);
        applyStimulus(0, 1, 1, 4'd4);
        checkOutput("up_not_yet_locked", 32'(locked), 0);
        applyStimulus(0, 1, 1, 4'd0);
        checkOutput("up_locked", 32'(locked), 1);
        checkOutput("up_lock_wrap_uncounted", 32'(wrap_cnt), 0);
        applyStimulus(0, 1, 1, 4'd1);
        applyStimulus(0, 1, 1, 4'd2);
        applyStimulus(0, 1, 1, 4'd3);
        applyStimulus(0, 1, 1, 4'd4);
        checkOutput("up_expected_wrap", 32'(expected), 0);
        applyStimulus(0, 1, 1, 4'd0);
        checkOutput("up_wrapcnt", 32'(wrap_cnt), 1);
        checkOutput("up_errcnt", 32'(err_cnt), 0);
        checkOutput("up_still_locked", 32'(locked), 1);

        // Asynchronous reset mid-run with random inputs.
        sample_en = 1'b1;
        up_down   = 1'($urandom_range(0, 1));
        count_in  = 4'($urandom_range(0, 15));
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_locked", 32'(locked), 0);
        checkOutput("midrst_wrapcnt", 32'(wrap_cnt), 0);
        checkOutput("midrst_errcnt", 32'(err_cnt), 0);
        checkOutput("midrst_seqerr", 32'(seq_err), 0);
        checkOutput("midrst_rangeerr", 32'(range_err), 0);
        @(posedge clk);
        count_in = 4'($urandom_range(0, 15));
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 1, 1, 4'd2);
        checkOutput("postrst_hunt_locked", 32'(locked), 0);
        checkOutput("postrst_hunt_last", 32'(expected), 3);
        checkOutput("postrst_no_err", 32'(err_cnt), 0);

        // Down direction: 1,0,4 locks (wrap during LOCK not counted).
        applyStimulus(1, 0, 0, 4'd0);
        applyStimulus(0, 1, 0, 4'd1);
        applyStimulus(0, 1, 0, 4'd0);
        applyStimulus(0, 1, 0, 4'd4);
        checkOutput("dn_locked", 32'(locked), 1);
        checkOutput("dn_wrapcnt0", 32'(wrap_cnt), 0);
        checkOutput("dn_expected", 32'(expected), 3);
        applyStimulus(0, 1, 0, 4'd3);
        applyStimulus(0, 1, 0, 4'd2);
        applyStimulus(0, 1, 0, 4'd1);
        applyStimulus(0, 1, 0, 4'd0);
        applyStimulus(0, 1, 0, 4'd4);
        checkOutput("dn_wrapcnt1", 32'(wrap_cnt), 1);
        checkOutput("dn_errcnt", 32'(err_cnt), 0);

        // Sequence error from TRACK, then relock.
        applyStimulus(1, 0, 1, 4'd0);
        checkOutput("clr_wrapcnt", 32'(wrap_cnt), 0);
        applyStimulus(0, 1, 1, 4'd0);
        applyStimulus(0, 1, 1, 4'd1);
        applyStimulus(0, 1, 1, 4'd2);
        checkOutput("seq_locked", 32'(locked), 1);
        applyStimulus(0, 1, 1, 4'd4);
        checkOutput("seq_pulse", 32'(seq_err), 1);
        checkOutput("seq_errcnt", 32'(err_cnt), 1);
        checkOutput("seq_unlocked", 32'(locked), 0);
        applyStimulus(0, 0, 1, 4'd3);
        checkOutput("seq_pulse_end", 32'(seq_err), 0);
        applyStimulus(0, 1, 1, 4'd0);
        applyStimulus(0, 1, 1, 4'd1);
        checkOutput("seq_relocked", 32'(locked), 1);
        checkOutput("seq_errcnt_hold", 32'(err_cnt), 1);

        // Range error while locked returns to HUNT.
        applyStimulus(0, 1, 1, 4'd6);
        checkOutput("rng_pulse", 32'(range_err), 1);
        checkOutput("rng_errcnt", 32'(err_cnt), 2);
        checkOutput("rng_unlocked", 32'(locked), 0);
        checkOutput("rng_no_seqerr", 32'(seq_err), 0);
        applyStimulus(0, 1, 1, 4'd2);
        checkOutput("rng_pulse_end", 32'(range_err), 0);
        checkOutput("rng_hunt_noerr", 32'(err_cnt), 2);
        applyStimulus(0, 1, 1, 4'd3);
        applyStimulus(0, 1, 1, 4'd4);
        checkOutput("gap_locked", 32'(locked), 1);

        // Gaps with sample_en=0 leave everything unchanged.
        applyStimulus(0, 0, 1, 4'd1);
        applyStimulus(0, 0, 1, 4'd9);
        checkOutput("gap_still_locked", 32'(locked), 1);
        checkOutput("gap_no_seqerr", 32'(seq_err), 0);
        checkOutput("gap_no_rangeerr", 32'(range_err), 0);
        checkOutput("gap_expected", 32'(expected), 0);
        applyStimulus(0, 1, 1, 4'd0);
        checkOutput("gap_wrapcnt", 32'(wrap_cnt), 1);
        checkOutput("gap_errcnt", 32'(err_cnt), 2);

        // Clear beats a simultaneous (out-of-range) sample.
        applyStimulus(1, 1, 1, 4'd7);
        checkOutput("clr_errcnt", 32'(err_cnt), 0);
        checkOutput("clr_wrapcnt2", 32'(wrap_cnt), 0);
        checkOutput("clr_no_rangeerr", 32'(range_err), 0);
        checkOutput("clr_unlocked", 32'(locked), 0);

        // Saturation of err_cnt.
        for (int i = 0; i < 254; i++) applyStimulus(0, 1, 1, 4'd7);
        checkOutput("sat_254", 32'(err_cnt), 254);
        applyStimulus(0, 1, 1, 4'd15);
        checkOutput("sat_255", 32'(err_cnt), 255);
        for (int i = 0; i < 45; i++) applyStimulus(0, 1, 1, 4'd5);
        checkOutput("sat_hold", 32'(err_cnt), 255);
        checkOutput("sat_rangeerr", 32'(range_err), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
